// File: rtl/vx_fetch_pkg.sv
// Shared types and width helpers for the instruction fetch stage.
// Defaults describe the standard 4-warp, 4-thread core configuration.
package vx_fetch_pkg;

    localparam int DEF_NUM_WARPS   = 4;
    localparam int DEF_NUM_THREADS = 4;
    localparam int DEF_PC_BITS     = 31;
    localparam int DEF_UUID_WIDTH  = 44;

    // A single-warp core still carries a 1-bit warp id.
    function automatic int calc_nw_width(input int num_warps);
        return (num_warps > 1) ? $clog2(num_warps) : 1;
    endfunction

    localparam int DEF_NW_WIDTH = calc_nw_width(DEF_NUM_WARPS);

    typedef struct packed {
        logic [DEF_NW_WIDTH-1:0]    wid;
        logic [DEF_NUM_THREADS-1:0] tmask;
        logic [DEF_PC_BITS-1:0]     pc;
        logic [DEF_UUID_WIDTH-1:0]  uuid;
        logic [31:0]                instr;
    } fetch_t;

endpackage

// File: rtl/vx_fetch_if.sv
// Handshake bundle between the fetch stage and its scheduler, icache and decode neighbours.
// The master side is the fetch stage; the slave side is everything around it.
interface vx_fetch_if
    import vx_fetch_pkg::*;
#(
    parameter int NUM_WARPS   = DEF_NUM_WARPS,
    parameter int NUM_THREADS = DEF_NUM_THREADS,
    parameter int PC_BITS     = DEF_PC_BITS,
    parameter int UUID_WIDTH  = DEF_UUID_WIDTH
) ();

    localparam int NW_WIDTH = calc_nw_width(NUM_WARPS);

    logic                   sched_valid;
    logic                   sched_ready;
    logic [NW_WIDTH-1:0]    sched_wid;
    logic [NUM_THREADS-1:0] sched_tmask;
    logic [PC_BITS-1:0]     sched_pc;
    logic [UUID_WIDTH-1:0]  sched_uuid;

    logic                   icache_req_valid;
    logic                   icache_req_ready;
    logic [PC_BITS-2:0]     icache_req_addr;
    logic [NW_WIDTH-1:0]    icache_req_tag;

    logic                   icache_rsp_valid;
    logic                   icache_rsp_ready;
    logic [31:0]            icache_rsp_data;
    logic [NW_WIDTH-1:0]    icache_rsp_tag;

    logic                   fetch_valid;
    logic                   fetch_ready;
    logic [NW_WIDTH-1:0]    fetch_wid;
    logic [NUM_THREADS-1:0] fetch_tmask;
    logic [PC_BITS-1:0]     fetch_pc;
    logic [UUID_WIDTH-1:0]  fetch_uuid;
    logic [31:0]            fetch_instr;

    logic                   busy;

    modport master (
        input  sched_valid, sched_wid, sched_tmask, sched_pc, sched_uuid,
        output sched_ready,
        output icache_req_valid, icache_req_addr, icache_req_tag,
        input  icache_req_ready,
        input  icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
        output icache_rsp_ready,
        output fetch_valid, fetch_wid, fetch_tmask, fetch_pc, fetch_uuid, fetch_instr,
        input  fetch_ready,
        output busy
    );

    modport slave (
        output sched_valid, sched_wid, sched_tmask, sched_pc, sched_uuid,
        input  sched_ready,
        input  icache_req_valid, icache_req_addr, icache_req_tag,
        output icache_req_ready,
        output icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
        input  icache_rsp_ready,
        input  fetch_valid, fetch_wid, fetch_tmask, fetch_pc, fetch_uuid, fetch_instr,
        output fetch_ready,
        input  busy
    );

endinterface

// File: rtl/vx_fetch_tag_table.sv
// Per-warp context table ({tmask, pc, uuid}) with one pending bit per warp marking
// that an icache request for that warp is outstanding.
module vx_fetch_tag_table
    import vx_fetch_pkg::*;
#(
    parameter  int NUM_WARPS   = DEF_NUM_WARPS,
    parameter  int NUM_THREADS = DEF_NUM_THREADS,
    parameter  int PC_BITS     = DEF_PC_BITS,
    parameter  int UUID_WIDTH  = DEF_UUID_WIDTH,
    localparam int NW_WIDTH    = calc_nw_width(NUM_WARPS),
    localparam int ENTRY_W     = NUM_THREADS + PC_BITS + UUID_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_wr_en,
    input  logic [NW_WIDTH-1:0]  i_wr_addr,
    input  logic [ENTRY_W-1:0]   i_wr_data,
    input  logic [NW_WIDTH-1:0]  i_rd_addr,
    output logic [ENTRY_W-1:0]   o_rd_data,
    input  logic                 i_set_en,
    input  logic [NW_WIDTH-1:0]  i_set_idx,
    input  logic                 i_clr_en,
    input  logic [NW_WIDTH-1:0]  i_clr_idx,
    output logic [NUM_WARPS-1:0] o_pending,
    output logic                 o_any_pending_nxt
);

    logic [ENTRY_W-1:0]   r_mem [NUM_WARPS];
    logic [NUM_WARPS-1:0] r_pending;
    logic [NUM_WARPS-1:0] w_pending_nxt;

    // NOTE: table storage has no reset; the pending bits alone say which entries are live.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

    // NOTE: blocking assignments with a default first keep this purely combinational (no latch).
    always_comb begin
        w_pending_nxt = r_pending;
        if (i_set_en) begin
            w_pending_nxt[i_set_idx] = 1'b1;
        end
        if (i_clr_en) begin
            w_pending_nxt[i_clr_idx] = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign o_pending         = r_pending;
    assign o_any_pending_nxt = |w_pending_nxt;

endmodule

// File: rtl/vx_fetch.sv
// Instruction fetch stage: accepts warp schedules, issues one icache request at a time
// and returns fetched instructions with their warp context in icache response order.
module vx_fetch
    import vx_fetch_pkg::*;
#(
    parameter int NUM_WARPS   = DEF_NUM_WARPS,
    parameter int NUM_THREADS = DEF_NUM_THREADS,
    parameter int PC_BITS     = DEF_PC_BITS,
    parameter int UUID_WIDTH  = DEF_UUID_WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    vx_fetch_if.master bus
);

    localparam int NW_WIDTH = calc_nw_width(NUM_WARPS);
    localparam int ENTRY_W  = NUM_THREADS + PC_BITS + UUID_WIDTH;
    localparam int OUT_W    = NW_WIDTH + ENTRY_W + 32;

    logic                 r_alive;
    logic                 r_req_full;
    logic                 w_req_full_nxt;
    logic [PC_BITS-2:0]   r_req_addr;
    logic [NW_WIDTH-1:0]  r_req_tag;

    logic [OUT_W-1:0]     r_out_mem [2];
    logic                 r_out_wr_ptr;
    logic                 r_out_rd_ptr;
    logic [1:0]           r_out_count;
    logic [1:0]           w_out_count_nxt;
    logic                 r_busy;

    logic [NUM_WARPS-1:0] w_pending;
    logic                 w_any_pending_nxt;
    logic [ENTRY_W-1:0]   w_rd_entry;

    logic                 w_sched_fire;
    logic                 w_req_fire;
    logic                 w_rsp_fire;
    logic                 w_fetch_fire;

    // r_alive holds the ready outputs low until the first clock after reset release.
    assign bus.sched_ready      = r_alive & ~r_req_full & ~w_pending[bus.sched_wid];
    assign bus.icache_req_valid = r_req_full;
    assign bus.icache_req_addr  = r_req_addr;
    assign bus.icache_req_tag   = r_req_tag;
    assign bus.icache_rsp_ready = r_alive & (r_out_count != 2'd2);
    assign bus.fetch_valid      = (r_out_count != 2'd0);
    assign bus.busy             = r_busy;

    assign {bus.fetch_wid, bus.fetch_tmask, bus.fetch_pc, bus.fetch_uuid, bus.fetch_instr} =
        r_out_mem[r_out_rd_ptr];

    assign w_sched_fire = bus.sched_valid & bus.sched_ready;
    assign w_req_fire   = r_req_full & bus.icache_req_ready;
    assign w_rsp_fire   = bus.icache_rsp_valid & bus.icache_rsp_ready;
    assign w_fetch_fire = bus.fetch_valid & bus.fetch_ready;

    vx_fetch_tag_table #(
        .NUM_WARPS   (NUM_WARPS),
        .NUM_THREADS (NUM_THREADS),
        .PC_BITS     (PC_BITS),
        .UUID_WIDTH  (UUID_WIDTH)
    ) u_tag_table (
        .clk               (clk),
        .reset             (reset),
        .i_wr_en           (w_sched_fire),
        .i_wr_addr         (bus.sched_wid),
        .i_wr_data         ({bus.sched_tmask, bus.sched_pc, bus.sched_uuid}),
        .i_rd_addr         (bus.icache_rsp_tag),
        .o_rd_data         (w_rd_entry),
        .i_set_en          (w_sched_fire),
        .i_set_idx         (bus.sched_wid),
        .i_clr_en          (w_rsp_fire),
        .i_clr_idx         (bus.icache_rsp_tag),
        .o_pending         (w_pending),
        .o_any_pending_nxt (w_any_pending_nxt)
    );

    // A new schedule reloads the request buffer even if the old request leaves this cycle.
    always_comb begin
        w_req_full_nxt = r_req_full;
        if (w_sched_fire) begin
            w_req_full_nxt = 1'b1;
        end else if (w_req_fire) begin
            w_req_full_nxt = 1'b0;
        end

        w_out_count_nxt = r_out_count;
        case ({w_rsp_fire, w_fetch_fire})
            2'b10:   w_out_count_nxt = r_out_count + 2'd1;
            2'b01:   w_out_count_nxt = r_out_count - 2'd1;
            default: w_out_count_nxt = r_out_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alive      <= 1'b0;
            r_req_full   <= 1'b0;
            r_req_addr   <= '0;
            r_req_tag    <= '0;
            r_out_wr_ptr <= 1'b0;
            r_out_rd_ptr <= 1'b0;
            r_out_count  <= 2'd0;
            r_busy       <= 1'b0;
        end else begin
            r_alive    <= 1'b1;
            r_req_full <= w_req_full_nxt;
            if (w_sched_fire) begin
                r_req_addr <= bus.sched_pc[PC_BITS-1:1];
                r_req_tag  <= bus.sched_wid;
            end
            if (w_rsp_fire) begin
                r_out_wr_ptr <= ~r_out_wr_ptr;
            end
            if (w_fetch_fire) begin
                r_out_rd_ptr <= ~r_out_rd_ptr;
            end
            r_out_count <= w_out_count_nxt;
            // Built from next-state terms so busy tracks the state it summarises.
            r_busy      <= w_any_pending_nxt | w_req_full_nxt | (w_out_count_nxt != 2'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_rsp_fire) begin
            r_out_mem[r_out_wr_ptr] <= {bus.icache_rsp_tag, w_rd_entry, bus.icache_rsp_data};
        end
    end

    // A response may only return for a warp that still has a request outstanding.
    assert property (@(posedge clk) disable iff (!reset)
        w_rsp_fire |-> w_pending[bus.icache_rsp_tag])
    else $error("icache response for warp %0d with no outstanding request", bus.icache_rsp_tag);

endmodule

// File: tb/tb_vx_fetch.sv
// Directed bench for vx_fetch: a transaction-level model (per-warp table, request and
// output queues) is compared against the DUT every cycle, plus hand-computed spot checks.
module tb_vx_fetch;
    import vx_fetch_pkg::*;

    localparam int NWARPS = DEF_NUM_WARPS;
    localparam int NT     = DEF_NUM_THREADS;
    localparam int PCB    = DEF_PC_BITS;
    localparam int UW     = DEF_UUID_WIDTH;
    localparam int NW     = DEF_NW_WIDTH;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vx_fetch_if #(.NUM_WARPS(NWARPS), .NUM_THREADS(NT), .PC_BITS(PCB), .UUID_WIDTH(UW)) bus ();

    vx_fetch #(.NUM_WARPS(NWARPS), .NUM_THREADS(NT), .PC_BITS(PCB), .UUID_WIDTH(UW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct packed {
        logic [PCB-2:0] addr;
        logic [NW-1:0]  tag;
    } req_t;

    logic [NT-1:0]  m_tmask [NWARPS];
    logic [PCB-1:0] m_pc    [NWARPS];
    logic [UW-1:0]  m_uuid  [NWARPS];
    bit             m_pending [NWARPS];
    bit             m_alive;
    req_t           m_req_q[$];
    fetch_t         m_out_q[$];
    int             seen_wid[$];

    bit     s_rdy, rsp_rdy, f_fire, rq_fire;
    req_t   new_req;
    fetch_t new_out;

    function automatic bit model_busy();
        bit b;
        b = (m_req_q.size() != 0) || (m_out_q.size() != 0);
        for (int i = 0; i < NWARPS; i++) b |= m_pending[i];
        return b;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_alive = 1'b0;
            for (int i = 0; i < NWARPS; i++) m_pending[i] = 1'b0;
            m_req_q.delete();
            m_out_q.delete();
        end else begin
            s_rdy   = m_alive && (m_req_q.size() == 0) && !m_pending[bus.sched_wid];
            rsp_rdy = m_alive && (m_out_q.size() < 2);
            f_fire  = (m_out_q.size() != 0) && bus.fetch_ready;
            rq_fire = (m_req_q.size() != 0) && bus.icache_req_ready;
            if (f_fire) begin
                seen_wid.push_back(int'(m_out_q[0].wid));
                void'(m_out_q.pop_front());
            end
            if (bus.icache_rsp_valid && rsp_rdy) begin
                new_out.wid   = bus.icache_rsp_tag;
                new_out.tmask = m_tmask[bus.icache_rsp_tag];
                new_out.pc    = m_pc[bus.icache_rsp_tag];
                new_out.uuid  = m_uuid[bus.icache_rsp_tag];
                new_out.instr = bus.icache_rsp_data;
                m_out_q.push_back(new_out);
                m_pending[bus.icache_rsp_tag] = 1'b0;
            end
            if (rq_fire) void'(m_req_q.pop_front());
            if (bus.sched_valid && s_rdy) begin
                m_tmask[bus.sched_wid]   = bus.sched_tmask;
                m_pc[bus.sched_wid]      = bus.sched_pc;
                m_uuid[bus.sched_wid]    = bus.sched_uuid;
                m_pending[bus.sched_wid] = 1'b1;
                new_req.addr = bus.sched_pc[PCB-1:1];
                new_req.tag  = bus.sched_wid;
                m_req_q.push_back(new_req);
            end
            m_alive = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            check("rst_sched_ready", bus.sched_ready, 0);
            check("rst_req_valid", bus.icache_req_valid, 0);
            check("rst_rsp_ready", bus.icache_rsp_ready, 0);
            check("rst_fetch_valid", bus.fetch_valid, 0);
            check("rst_busy", bus.busy, 0);
        end else begin
            check("sched_ready", bus.sched_ready,
                  m_alive && (m_req_q.size() == 0) && !m_pending[bus.sched_wid]);
            check("req_valid", bus.icache_req_valid, m_req_q.size() != 0);
            if (m_req_q.size() != 0) begin
                check("req_addr", bus.icache_req_addr, m_req_q[0].addr);
                check("req_tag", bus.icache_req_tag, m_req_q[0].tag);
            end
            check("rsp_ready", bus.icache_rsp_ready, m_alive && (m_out_q.size() < 2));
            check("fetch_valid", bus.fetch_valid, m_out_q.size() != 0);
            if (m_out_q.size() != 0) begin
                check("fetch_wid", bus.fetch_wid, m_out_q[0].wid);
                check("fetch_tmask", bus.fetch_tmask, m_out_q[0].tmask);
                check("fetch_pc", bus.fetch_pc, m_out_q[0].pc);
                check("fetch_uuid", bus.fetch_uuid, m_out_q[0].uuid);
                check("fetch_instr", bus.fetch_instr, m_out_q[0].instr);
            end
            check("busy", bus.busy, model_busy());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic schedule(input int wid, input logic [NT-1:0] tm, input logic [PCB-1:0] pc,
                            input logic [UW-1:0] uuid);
        bit fired = 1'b0;
        logic [31:0] w = wid;
        bus.sched_valid = 1'b1;
        bus.sched_wid   = w[NW-1:0];
        bus.sched_tmask = tm;
        bus.sched_pc    = pc;
        bus.sched_uuid  = uuid;
        for (int i = 0; i < 50 && !fired; i++) begin
            @(negedge clk);
            fired = bus.sched_ready;
            tick();
        end
        bus.sched_valid = 1'b0;
        check("sched_accepted", fired, 1);
    endtask

    task automatic respond(input int tag, input logic [31:0] data);
        bit fired = 1'b0;
        logic [31:0] t = tag;
        bus.icache_rsp_valid = 1'b1;
        bus.icache_rsp_tag   = t[NW-1:0];
        bus.icache_rsp_data  = data;
        for (int i = 0; i < 50 && !fired; i++) begin
            @(negedge clk);
            fired = bus.icache_rsp_ready;
            tick();
        end
        bus.icache_rsp_valid = 1'b0;
        check("rsp_accepted", fired, 1);
    endtask

    int exp4[4] = '{3, 0, 2, 1};
    int exp5[3] = '{0, 1, 2};

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset                = 1'b0;
        bus.sched_valid      = 1'b0;
        bus.sched_wid        = '0;
        bus.sched_tmask      = '0;
        bus.sched_pc         = '0;
        bus.sched_uuid       = '0;
        bus.icache_req_ready = 1'b1;
        bus.icache_rsp_valid = 1'b0;
        bus.icache_rsp_tag   = '0;
        bus.icache_rsp_data  = '0;
        bus.fetch_ready      = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("ready_after_release", bus.sched_ready, 1);
        tick();

        // Scenario 1: single fetch, word address = pc >> 1.
        schedule(1, 4'b1011, 31'h40, 44'h111);
        @(negedge clk);
        check("s1_req_valid", bus.icache_req_valid, 1);
        check("s1_req_addr", bus.icache_req_addr, 30'h20);
        check("s1_req_tag", bus.icache_req_tag, 1);
        tick();
        tick();
        respond(1, 32'h0000_0013);
        @(negedge clk);
        check("s1_fetch_valid", bus.fetch_valid, 1);
        check("s1_fetch_wid", bus.fetch_wid, 1);
        check("s1_fetch_tmask", bus.fetch_tmask, 4'b1011);
        check("s1_fetch_pc", bus.fetch_pc, 31'h40);
        check("s1_fetch_instr", bus.fetch_instr, 32'h0000_0013);
        tick();
        tick();

        // Scenario 2: second schedule for a pending warp waits for its response.
        schedule(2, 4'b0110, 31'h80, 44'h222);
        tick();
        tick();
        bus.sched_valid = 1'b1;
        bus.sched_wid   = 2'd2;
        bus.sched_tmask = 4'b0011;
        bus.sched_pc    = 31'h84;
        bus.sched_uuid  = 44'h223;
        repeat (3) begin
            @(negedge clk);
            check("s2_blocked", bus.sched_ready, 0);
            tick();
        end
        bus.icache_rsp_valid = 1'b1;
        bus.icache_rsp_tag   = 2'd2;
        bus.icache_rsp_data  = 32'h0010_0093;
        @(negedge clk);
        check("s2_rsp_ready", bus.icache_rsp_ready, 1);
        check("s2_still_blocked", bus.sched_ready, 0);
        tick();
        bus.icache_rsp_valid = 1'b0;
        @(negedge clk);
        check("s2_ready_after_rsp", bus.sched_ready, 1);
        tick();
        bus.sched_valid = 1'b0;
        tick();
        tick();
        respond(2, 32'h0020_0113);
        tick();

        // Scenario 3: icache stalls, request held stable, no new schedule.
        bus.icache_req_ready = 1'b0;
        schedule(3, 4'b1111, 31'h100, 44'h333);
        bus.sched_valid = 1'b1;
        bus.sched_wid   = 2'd0;
        bus.sched_pc    = 31'h10;
        repeat (5) begin
            @(negedge clk);
            check("s3_req_valid", bus.icache_req_valid, 1);
            check("s3_req_addr", bus.icache_req_addr, 30'h80);
            check("s3_req_tag", bus.icache_req_tag, 3);
            check("s3_sched_blocked", bus.sched_ready, 0);
            tick();
        end
        bus.sched_valid      = 1'b0;
        bus.icache_req_ready = 1'b1;
        tick();
        respond(3, 32'h0030_0193);
        tick();

        // Scenario 4: out-of-order responses come out in response order.
        for (int w = 0; w < 4; w++) begin
            logic [31:0] wv = w;
            schedule(w, wv[3:0] + 4'd1, 31'h200 + 31'(w * 16), 44'h400 + 44'(w));
        end
        tick();
        seen_wid.delete();
        respond(3, 32'hAAAA_0003);
        respond(0, 32'hAAAA_0000);
        respond(2, 32'hAAAA_0002);
        respond(1, 32'hAAAA_0001);
        repeat (3) tick();
        check("s4_count", seen_wid.size(), 4);
        for (int i = 0; i < 4; i++) check("s4_order", seen_wid[i], exp4[i]);

        // Scenario 5: decode stalls; two responses buffered, third held off.
        bus.fetch_ready = 1'b0;
        schedule(0, 4'b0001, 31'h500, 44'h500);
        schedule(1, 4'b0010, 31'h510, 44'h501);
        schedule(2, 4'b0100, 31'h520, 44'h502);
        tick();
        seen_wid.delete();
        respond(0, 32'hBBBB_0000);
        respond(1, 32'hBBBB_0001);
        bus.icache_rsp_valid = 1'b1;
        bus.icache_rsp_tag   = 2'd2;
        bus.icache_rsp_data  = 32'hBBBB_0002;
        repeat (3) begin
            @(negedge clk);
            check("s5_rsp_blocked", bus.icache_rsp_ready, 0);
            check("s5_fetch_valid", bus.fetch_valid, 1);
            tick();
        end
        bus.fetch_ready = 1'b1;
        respond(2, 32'hBBBB_0002);
        repeat (4) tick();
        check("s5_count", seen_wid.size(), 3);
        for (int i = 0; i < 3; i++) check("s5_order", seen_wid[i], exp5[i]);

        // Scenario 6: reset with two requests in flight, then a fresh schedule.
        schedule(0, 4'b1001, 31'h600, 44'h600);
        tick();
        schedule(1, 4'b1010, 31'h610, 44'h601);
        reset = 1'b0;
        @(negedge clk);
        check("s6_sched_ready", bus.sched_ready, 0);
        check("s6_req_valid", bus.icache_req_valid, 0);
        check("s6_rsp_ready", bus.icache_rsp_ready, 0);
        check("s6_fetch_valid", bus.fetch_valid, 0);
        check("s6_busy", bus.busy, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        seen_wid.delete();
        schedule(0, 4'b1100, 31'h300, 44'h700);
        tick();
        respond(0, 32'hCCCC_0000);
        repeat (2) tick();
        check("s6_count", seen_wid.size(), 1);
        check("s6_wid", seen_wid[0], 0);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
